// File: rtl/apb_node_timeout.sv
`default_nettype none
// ============================================================================
// Module      : apb_node_timeout
// Description : APB 1-to-N node with registered address decode, setup/access
//               FSM, PSLVERR on decode miss and per-transaction timeout.
//               Optional sticky error log enabled by APB_NODE_ERR_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_node_timeout #(
   parameter int NB_MASTER      = 26,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
   input  logic                                pwrite_i,
   input  logic                                psel_i,
   input  logic                                penable_i,
   output logic [APB_DATA_WIDTH-1:0]           prdata_o,
   output logic                                pready_o,
   output logic                                pslverr_o,
   output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
   output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
   output logic                                pwrite_o,
   output logic [NB_MASTER-1:0]                psel_o,
   output logic                                penable_o,
   input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
   input  logic [NB_MASTER-1:0]                pready_i,
   input  logic [NB_MASTER-1:0]                pslverr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i
`ifdef APB_NODE_ERR_LOG_EN
   ,
   input  logic                                err_clr_i,
   output logic                                err_valid_o,
   output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
   output logic [1:0]                          err_cause_o
`endif
);

   localparam int c_idx_w = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
   localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit c_tmo_en = (TIMEOUT_CYCLES > 0);
   localparam logic [c_cnt_w-1:0] c_cnt_limit =
      c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_setup  = 2'd1;
   localparam logic [1:0] c_st_access = 2'd2;
   localparam logic [1:0] c_st_resp   = 2'd3;

   logic [1:0]                r_state;
   logic [1:0]                w_next_state;
   logic [c_idx_w-1:0]        r_idx;
   logic [APB_ADDR_WIDTH-1:0] r_addr;
   logic [APB_DATA_WIDTH-1:0] r_wdata;
   logic                      r_write;
   logic [APB_DATA_WIDTH-1:0] r_rdata;
   logic                      r_err;
   logic                      r_abort;
   logic [c_cnt_w-1:0]        r_cnt;

   logic [NB_MASTER-1:0]      w_hit;
   logic                      w_hit_any;
   logic [c_idx_w-1:0]        w_hit_idx;
   logic                      w_accept;
   logic                      w_sel_ready;
   logic                      w_sel_err;
   logic [APB_DATA_WIDTH-1:0] w_sel_rdata;
   logic                      w_expire;
   logic                      w_miss_evt;
   logic                      w_slave_evt;
   logic                      w_tmo_evt;

   // ---------------------------------------------------------------- decode
   for (genvar k = 0; k < NB_MASTER; k++) begin : g_decode
      assign w_hit[k] = (paddr_i >= start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                        (paddr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
   end

   assign w_hit_any = |w_hit;

   // Scanning downward lets the lowest matching index overwrite the others.
   always_comb begin
      w_hit_idx = '0;
      for (int k = NB_MASTER - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            w_hit_idx = c_idx_w'(k);
         end
      end
   end

   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_err   = 1'b0;
      w_sel_rdata = '0;
      for (int k = 0; k < NB_MASTER; k++) begin
         if (r_idx == c_idx_w'(k)) begin
            w_sel_ready = pready_i[k];
            w_sel_err   = pslverr_i[k];
            w_sel_rdata = prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
         end
      end
   end

   assign w_accept    = (r_state == c_st_idle) && psel_i && !penable_i;
   assign w_expire    = c_tmo_en && (r_cnt == c_cnt_limit);
   assign w_miss_evt  = w_accept && !w_hit_any;
   assign w_slave_evt = (r_state == c_st_access) && w_sel_ready;
   assign w_tmo_evt   = (r_state == c_st_access) && !w_sel_ready && w_expire;

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_accept) begin
               w_next_state = w_hit_any ? c_st_setup : c_st_resp;
            end
         end
         c_st_setup:  w_next_state = c_st_access;
         c_st_access: begin
            if (w_sel_ready || w_expire) begin
               w_next_state = c_st_resp;
            end
         end
         default:     w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      psel_o    = '0;
      penable_o = 1'b0;
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      prdata_o  = '0;
      case (r_state)
         c_st_setup, c_st_access: begin
            for (int k = 0; k < NB_MASTER; k++) begin
               psel_o[k] = (r_idx == c_idx_w'(k));
            end
            penable_o = (r_state == c_st_access);
         end
         c_st_resp: begin
            // An upstream that dropped psel mid-transaction gets no response.
            pready_o  = !r_abort;
            pslverr_o = !r_abort && r_err;
            prdata_o  = r_abort ? '0 : r_rdata;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_idx   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_abort <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_abort <= 1'b0;
               if (w_accept) begin
                  r_addr  <= paddr_i;
                  r_wdata <= pwdata_i;
                  r_write <= pwrite_i;
                  r_idx   <= w_hit_idx;
                  if (!w_hit_any) begin
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                  end
               end
            end
            c_st_setup: begin
               r_cnt <= '0;
               if (!psel_i) begin
                  r_abort <= 1'b1;
               end
            end
            c_st_access: begin
               if (!psel_i) begin
                  r_abort <= 1'b1;
               end
               if (w_sel_ready) begin
                  r_rdata <= w_sel_rdata;
                  r_err   <= w_sel_err;
               end else begin
                  if (r_cnt != c_cnt_max) begin
                     r_cnt <= r_cnt + c_cnt_w'(1);
                  end
                  if (w_expire) begin
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign paddr_o  = r_addr;
   assign pwdata_o = r_wdata;
   assign pwrite_o = r_write;

`ifdef APB_NODE_ERR_LOG_EN
   // -------------------------------------------------------------- error log
   logic [1:0]                r_cause;
   logic                      r_err_valid;
   logic [APB_ADDR_WIDTH-1:0] r_err_addr;
   logic [1:0]                r_err_cause;
   logic                      w_log_capture;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cause <= 2'b00;
      end else if (w_miss_evt) begin
         r_cause <= 2'b01;
      end else if (w_tmo_evt) begin
         r_cause <= 2'b10;
      end else if (w_slave_evt) begin
         r_cause <= w_sel_err ? 2'b11 : 2'b00;
      end
   end

   // A clear coinciding with a new error lets the new error through.
   assign w_log_capture = (r_state == c_st_resp) && r_err && (!r_err_valid || err_clr_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cause <= 2'b00;
      end else if (w_log_capture) begin
         r_err_valid <= 1'b1;
         r_err_addr  <= r_addr;
         r_err_cause <= r_cause;
      end else if (err_clr_i) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cause <= 2'b00;
      end
   end

   assign err_valid_o = r_err_valid;
   assign err_addr_o  = r_err_addr;
   assign err_cause_o = r_err_cause;
`else
   logic w_evt_unused;
   assign w_evt_unused = w_slave_evt ^ w_tmo_evt ^ w_miss_evt;
`endif

endmodule
`default_nettype wire
